spi_master: RTL

- Mode-0 SPI initiator: shifts one byte out on mosi while capturing one byte from miso, MSB first, with a single active-low slave select.
- It is the controller end of the link served by spi_slave. It lets the FPGA drive external SPI peripherals, and it is the bus driver in spi_slave loopback benches.
- Serial clock is derived from clk by a programmable half-period counter (default 100 MHz to 500 kHz).

---
 rtl/spi_master.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/spi_master.sv
// Mode-0 SPI initiator: one WIDTH-bit full-duplex transfer per start, MSB first,
// with sclk derived from clk by a CLK_DIV half-period counter.
module spi_master #(
  parameter int CLK_DIV = 100,
  parameter int WIDTH   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             done,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso,
  output logic             ssel
);

  localparam int CW = $clog2(CLK_DIV) + 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
  // HOLD spans the final low phase plus the CLK_DIV guard before ssel rises.
  localparam logic [CW-1:0] HOLD_LAST = CW'(2 * CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_HOLD  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             ssel_q, ssel_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // State and datapath registers; reset aborts any transfer at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ssel_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ssel_q  <= ssel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output logic for the transfer sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    ssel_d  = ssel_q;
    busy_d  = busy_q;
    done_d  = done_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          tx_d    = din;
          bit_d   = '0;
          ssel_d  = 1'b0;
          mosi_d  = din[WIDTH-1];
          busy_d  = 1'b1;
          state_d = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SETUP, S_LOW: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_HIGH: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d  = '0;
          sclk_d = 1'b0;
          // Sampling late in the high phase absorbs a slave's miso latency.
          rx_d   = {rx_q[WIDTH-2:0], miso};
          if (bit_q == BIT_LAST) begin
            state_d = S_HOLD;
          end else begin
            bit_d   = bit_q + BW'(1);
            tx_d    = {tx_q[WIDTH-2:0], 1'b0};
            mosi_d  = tx_q[WIDTH-2];
            state_d = S_LOW;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          ssel_d  = 1'b1;
          mosi_d  = 1'b0;
          done_d  = 1'b1;
          dout_d  = rx_q;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
        ssel_d  = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  assign dout = dout_q;
  assign busy = busy_q;
  assign done = done_q;
  assign sclk = sclk_q;
  assign mosi = mosi_q;
  assign ssel = ssel_q;

endmodule
